mac_result_fifo: RTL
====================

# mac_result_fifo

- Sits directly downstream of the sum-of-squares accumulator.
- Captures each valid 20-bit accumulator result (`f` qualified by `valid_out`) into a small register-based FIFO.
- Presents the results to the next stage over a valid/ready handshake, so a stalled consumer never loses a sample silently.
- Samples that arrive while the FIFO is full are dropped and counted; optionally, accumulator wrap-around is flagged per entry.

## Interface
- `DATA_W`, default 20: result width; matches the accumulator output width.
- `DEPTH`, default 8: FIFO entries; must be a power of two, ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset; clears all state immediately.
- `valid_in` in 1: sample strobe, driven from the accumulator's `valid_out`.
- `data_in` in DATA_W: sample value, driven from the accumulator's `f`.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts the head entry this cycle.
- `data_out` out DATA_W: head entry data.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out $clog2(DEPTH)+1: number of stored entries.
- `drop_cnt` out 8: number of samples dropped because the FIFO was full; saturating.
- `out_ovf` out 1: wrap flag of the head entry. Present only with `MAC_RESULT_OVF_DETECT_EN`.

## Operation
- push = `valid_in && (!full || pop)`.
- pop = `out_valid && out_ready`.
- push and pop in the same cycle: both happen; count is unchanged.
- Dropped sample: `valid_in && full && !pop`. On a drop, `drop_cnt` increments, holds at 255, and the entry is not stored.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - full when the MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
- Output mode is first-word fall-through:
  - `out_valid` = !empty.
  - `data_out` = mem[rd_ptr] when !empty, else 0.
- `out_ready` while empty: ignored; no state changes.
- `valid_in` while empty with `out_ready` = 1: push only. The entry is not popped in the same cycle.
- Storage array has no reset; only pointers, counters, flags and `prev` are reset.
- Reset values:
  - `out_valid` = 0, `empty` = 1, `full` = 0, `count` = 0, `drop_cnt` = 0, `data_out` = 0.
  - `out_ovf` = 0; internal `prev` = 0.
- Reset mid-operation: all stored entries are discarded immediately (asynchronous). Any push or pop in that cycle is lost.

## Timing
- Latency: a sample pushed at edge k appears on `out_valid`/`data_out` after edge k, i.e. in the cycle following the cycle `valid_in` was high.
- Combinational paths:
  - Output signals depend only on registers.
  - `out_ready` → push-accept (when full) is combinational.
  - No combinational path from `valid_in` to any output.
- Throughput: one push and one pop per cycle sustained.
- `count`, `full` and `empty` update on the same edge as the pointer they reflect.

## Configuration
- Macro: `MAC_RESULT_OVF_DETECT_EN`.
- Defined:
  - Each entry stores an extra bit: ovf = `data_in < prev`, evaluated on every `valid_in` cycle.
  - `prev` updates to `data_in` on every `valid_in`, including dropped samples.
  - The head entry's bit drives `out_ovf`.
- Not defined: no `out_ovf` port, no `prev` register; entries are DATA_W bits.

## Structure
- Package `mac_result_pkg`:
  - `DATA_W_DEF` = 20.
  - `DEPTH_DEF` = 8.
  - `DROP_CNT_W` = 8.
  - Typedef `result_entry_t`: packed struct {ovf bit (under macro), data[DATA_W-1:0]}.
- One sub-module, `mac_result_mem`: register array with write port (we, waddr, wdata) and asynchronous read port (raddr → rdata); no reset.
- Pointer logic, counters and flags stay in the top level.

## Test plan
- Reset: assert `reset` with no clock edge → `out_valid`=0, `empty`=1, `count`=0, `drop_cnt`=0, `data_out`=0.
- Push 441 then 1737 with `out_ready`=0 → `count`=2, `data_out`=441. Then `out_ready`=1 for two cycles → 441 then 1737 consumed, `empty`=1.
- Fill 1..8 with `out_ready`=0, then push 9 → dropped: `drop_cnt`=1, `full` stays 1. Then push 10 with `out_ready`=1 → 1 popped, 10 accepted, `count`=8, tail = 10.
- Count 1 (value 5833), push 70858 with `out_ready`=1 → 5833 popped, `count` stays 1, `data_out`=70858 next cycle.
- With macro: push 1048000 then 500 → `out_ovf`=0 for the first entry and 1 for the second. Without macro: same data, no flag.
- Count 5: assert `reset` between edges → `empty`=1, `count`=0 immediately. After release, push 74954 → `data_out`=74954 after one cycle.

Source files
------------

// File: rtl/mac_result_pkg.sv
`default_nettype none
// ============================================================================
// mac_result_pkg: shared widths and entry layout for the MAC result FIFO.
// Rev 1.0
// ============================================================================
package mac_result_pkg;

  localparam int DATA_W_DEF = 20;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_CNT_W = 8;

  typedef struct packed {
`ifdef MAC_RESULT_OVF_DETECT_EN
    logic                  ovf;
`endif
    logic [DATA_W_DEF-1:0] data;
  } result_entry_t;

endpackage
`default_nettype wire

// File: rtl/mac_result_mem.sv
`default_nettype none
// ============================================================================
// mac_result_mem: register array, one synchronous write port, async read.
// Rev 1.0
// ============================================================================
module mac_result_mem #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Storage is deliberately unreset; the pointers define which entries are live.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mac_result_fifo.sv
`default_nettype none
// ============================================================================
// mac_result_fifo: first-word fall-through FIFO with drop counter behind the
// sum-of-squares accumulator; MAC_RESULT_OVF_DETECT_EN adds a per-entry wrap flag.
// Rev 1.0
// ============================================================================
module mac_result_fifo
  import mac_result_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_CNT_W-1:0]    drop_cnt
`ifdef MAC_RESULT_OVF_DETECT_EN
  ,
  output logic                     out_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef MAC_RESULT_OVF_DETECT_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                push;
  logic                pop;
  logic                drop;
  logic [ENTRY_W-1:0]  wdata;
  logic [ENTRY_W-1:0]  rdata;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign out_valid = !empty;

  assign pop  = out_valid && out_ready;
  assign push = valid_in && (!full || pop);
  assign drop = valid_in && full && !pop;

  assign data_out = empty ? '0 : rdata[DATA_W-1:0];

`ifdef MAC_RESULT_OVF_DETECT_EN
  logic [DATA_W-1:0] prev;

  // The wrap flag tracks every strobe, so prev follows dropped samples too.
  assign wdata   = {(data_in < prev), data_in};
  assign out_ovf = !empty && rdata[DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
    end else if (valid_in) begin
      prev <= data_in;
    end
  end
`else
  assign wdata = data_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop && (drop_cnt != {DROP_CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  mac_result_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule
`default_nettype wire
